// File: rtl/ppm16_mod_if.sv
// Handshake/stream bundle between the packet source, ppm16_mod and the emitter driver.
// The master side drives the packet source inputs; the slave side is the modulator.
interface ppm16_mod_if;
  logic        tx_start;
  logic [15:0] data_len_ext;
  logic [3:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        dout;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_underrun;

  modport master (
    output tx_start, data_len_ext, din, din_valid,
    input  din_ready, dout, tx_busy, tx_done, tx_underrun
  );

  modport slave (
    input  tx_start, data_len_ext, din, din_valid,
    output din_ready, dout, tx_busy, tx_done, tx_underrun
  );
endinterface

// File: rtl/ppm16_mod.sv
// 16-PPM packet modulator: preamble, 16-bit length header (MS nibble first), then data nibbles.
// Each symbol v emits one pulse in chip slot v of 16; every chip lasts CHIP_BITS clocks.
module ppm16_mod #(
  parameter int unsigned CHIP_BITS       = 1,
  parameter int unsigned PREAMBLE_LEN    = 8,
  parameter logic [3:0]  PREAMBLE_SYMBOL = 4'h0
) (
  input logic        clk,
  input logic        resetn,
  ppm16_mod_if.slave tx_bus
);

  localparam int unsigned CbW = (CHIP_BITS > 1) ? $clog2(CHIP_BITS) : 1;
  localparam logic [CbW-1:0] ChipBitLast = CbW'(CHIP_BITS - 1);
  localparam logic [16:0] PreambleLast = 17'(PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StPreamble, StHeader, StData} state_e;

  state_e         state_q, state_d;
  logic [15:0]    len_q, len_d;
  logic [CbW-1:0] chip_bit_cnt_q, chip_bit_cnt_d;
  logic [3:0]     chip_cnt_q, chip_cnt_d;
  logic [16:0]    sym_cnt_q, sym_cnt_d;
  logic [3:0]     cur_sym_q, cur_sym_d;
  logic [3:0]     buf_q, buf_d;
  logic           buf_full_q, buf_full_d;
  logic [16:0]    acc_cnt_q, acc_cnt_d;
  logic           dout_q, dout_d;
  logic           done_q, done_d;
  logic           underrun_q, underrun_d;

  logic        busy, din_ready, xfer, chip_bit_wrap, sym_end, load_data;
  logic [16:0] len_ext;

  assign len_ext       = {1'b0, len_q};
  assign busy          = (state_q != StIdle);
  assign din_ready     = busy && !buf_full_q && (acc_cnt_q < len_ext);
  assign xfer          = tx_bus.din_valid && din_ready;
  assign chip_bit_wrap = (chip_bit_cnt_q == ChipBitLast);
  assign sym_end       = chip_bit_wrap && (chip_cnt_q == 4'hF);

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    chip_bit_cnt_d = chip_bit_cnt_q;
    chip_cnt_d     = chip_cnt_q;
    sym_cnt_d      = sym_cnt_q;
    cur_sym_d      = cur_sym_q;
    buf_d          = buf_q;
    buf_full_d     = buf_full_q;
    acc_cnt_d      = acc_cnt_q;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
    load_data      = 1'b0;

    if (state_q == StIdle) begin
      if (tx_bus.tx_start) begin
        state_d        = StPreamble;
        len_d          = tx_bus.data_len_ext;
        chip_bit_cnt_d = '0;
        chip_cnt_d     = '0;
        sym_cnt_d      = '0;
        cur_sym_d      = PREAMBLE_SYMBOL;
        buf_full_d     = 1'b0;
        acc_cnt_d      = '0;
      end
    end else begin
      if (xfer) begin
        buf_d      = tx_bus.din;
        buf_full_d = 1'b1;
        acc_cnt_d  = acc_cnt_q + 17'd1;
      end

      if (chip_bit_wrap) begin
        chip_bit_cnt_d = '0;
        chip_cnt_d     = chip_cnt_q + 4'd1;
      end else begin
        chip_bit_cnt_d = chip_bit_cnt_q + CbW'(1);
      end

      if (sym_end) begin
        sym_cnt_d = sym_cnt_q + 17'd1;
        unique case (state_q)
          StPreamble: begin
            if (sym_cnt_q == PreambleLast) begin
              state_d   = StHeader;
              sym_cnt_d = '0;
              cur_sym_d = len_q[15:12];
            end else begin
              cur_sym_d = PREAMBLE_SYMBOL;
            end
          end
          StHeader: begin
            if (sym_cnt_q == 17'd3) begin
              if (len_q == 16'h0000) begin
                state_d = StIdle;
                done_d  = 1'b1;
              end else begin
                state_d   = StData;
                sym_cnt_d = '0;
                load_data = 1'b1;
              end
            end else begin
              unique case (sym_cnt_q[1:0])
                2'd0:    cur_sym_d = len_q[11:8];
                2'd1:    cur_sym_d = len_q[7:4];
                default: cur_sym_d = len_q[3:0];
              endcase
            end
          end
          StData: begin
            if (sym_cnt_q == len_ext - 17'd1) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              load_data = 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Buffer wins; otherwise a symbol accepted on this very edge bypasses the buffer.
      if (load_data) begin
        if (buf_full_q) begin
          cur_sym_d  = buf_q;
          buf_full_d = 1'b0;
        end else if (xfer) begin
          cur_sym_d  = tx_bus.din;
          buf_full_d = 1'b0;
        end else begin
          state_d    = StIdle;
          underrun_d = 1'b1;
        end
      end
    end

    if (state_d == StIdle) begin
      buf_full_d = 1'b0;
    end
    dout_d = (state_d != StIdle) && (chip_cnt_d == cur_sym_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      len_q          <= '0;
      chip_bit_cnt_q <= '0;
      chip_cnt_q     <= '0;
      sym_cnt_q      <= '0;
      cur_sym_q      <= '0;
      buf_q          <= '0;
      buf_full_q     <= 1'b0;
      acc_cnt_q      <= '0;
      dout_q         <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      chip_bit_cnt_q <= chip_bit_cnt_d;
      chip_cnt_q     <= chip_cnt_d;
      sym_cnt_q      <= sym_cnt_d;
      cur_sym_q      <= cur_sym_d;
      buf_q          <= buf_d;
      buf_full_q     <= buf_full_d;
      acc_cnt_q      <= acc_cnt_d;
      dout_q         <= dout_d;
      done_q         <= done_d;
      underrun_q     <= underrun_d;
    end
  end

  assign tx_bus.din_ready   = din_ready;
  assign tx_bus.dout        = dout_q;
  assign tx_bus.tx_busy     = busy;
  assign tx_bus.tx_done     = done_q;
  assign tx_bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_ppm16_mod.sv
// Directed bench for ppm16_mod: expected chip streams are queued at packet launch and
// popped against dout on every busy cycle; two instances cover CHIP_BITS=1 and CHIP_BITS=3.
module tb_ppm16_mod;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ppm16_mod_if a_if ();
  ppm16_mod_if b_if ();

  ppm16_mod #(.CHIP_BITS(1), .PREAMBLE_LEN(8), .PREAMBLE_SYMBOL(4'h0)) dut_a (
    .clk(clk), .resetn(resetn), .tx_bus(a_if.slave)
  );
  ppm16_mod #(.CHIP_BITS(3), .PREAMBLE_LEN(8), .PREAMBLE_SYMBOL(4'h0)) dut_b (
    .clk(clk), .resetn(resetn), .tx_bus(b_if.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  bit exp_a[$];
  bit exp_b[$];
  logic [3:0] feed_a[$];
  logic [3:0] feed_b[$];
  bit feed_en_a = 1'b0;
  bit feed_en_b = 1'b0;
  int busy_a = 0, busy_b = 0, done_a = 0, done_b = 0, und_a = 0, und_b = 0, ready_a = 0;
  bit fire_a = 1'b0, fire_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_sym(input bit sel_b, input logic [3:0] sym);
    for (int c = 0; c < 16; c++) begin
      if (sel_b) begin
        for (int b = 0; b < 3; b++) exp_b.push_back(4'(c) == sym);
      end else begin
        exp_a.push_back(4'(c) == sym);
      end
    end
  endfunction

  function automatic void push_frame(input bit sel_b, input logic [15:0] len);
    for (int i = 0; i < 8; i++) push_sym(sel_b, 4'h0);
    push_sym(sel_b, len[15:12]);
    push_sym(sel_b, len[11:8]);
    push_sym(sel_b, len[7:4]);
    push_sym(sel_b, len[3:0]);
  endfunction

  // One clock: observe both DUTs at the falling edge, update source inputs just after the rise.
  task automatic tick();
    @(negedge clk);
    if (a_if.tx_busy) begin
      busy_a++;
      if (exp_a.size() > 0) check("a_dout", 32'(a_if.dout), 32'(exp_a.pop_front()));
    end
    if (b_if.tx_busy) begin
      busy_b++;
      if (exp_b.size() > 0) check("b_dout", 32'(b_if.dout), 32'(exp_b.pop_front()));
    end
    if (a_if.tx_done) done_a++;
    if (b_if.tx_done) done_b++;
    if (a_if.tx_underrun) und_a++;
    if (b_if.tx_underrun) und_b++;
    if (a_if.din_ready) ready_a++;
    fire_a = a_if.din_valid && a_if.din_ready;
    fire_b = b_if.din_valid && b_if.din_ready;
    @(posedge clk);
    #1;
    if (fire_a) void'(feed_a.pop_front());
    if (fire_b) void'(feed_b.pop_front());
    a_if.din_valid = feed_en_a && (feed_a.size() > 0);
    a_if.din       = (feed_a.size() > 0) ? feed_a[0] : 4'h0;
    b_if.din_valid = feed_en_b && (feed_b.size() > 0);
    b_if.din       = (feed_b.size() > 0) ? feed_b[0] : 4'h0;
  endtask

  task automatic start(input bit sel_b, input logic [15:0] len);
    if (sel_b) begin
      b_if.data_len_ext = len;
      b_if.tx_start = 1'b1;
      tick();
      b_if.tx_start = 1'b0;
    end else begin
      a_if.data_len_ext = len;
      a_if.tx_start = 1'b1;
      tick();
      a_if.tx_start = 1'b0;
    end
  endtask

  task automatic wait_end(input bit sel_b, input string tag);
    int d0 = sel_b ? done_b : done_a;
    int u0 = sel_b ? und_b : und_a;
    bit ended = 1'b0;
    for (int i = 0; i < 3000 && !ended; i++) begin
      tick();
      ended = sel_b ? (done_b != d0 || und_b != u0) : (done_a != d0 || und_a != u0);
    end
    check({tag, "_end_seen"}, 32'(ended), 32'd1);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_dout"}, 32'(a_if.dout), 32'd0);
    check({tag, "_busy"}, 32'(a_if.tx_busy), 32'd0);
    check({tag, "_ready"}, 32'(a_if.din_ready), 32'd0);
    check({tag, "_done"}, 32'(a_if.tx_done), 32'd0);
    check({tag, "_underrun"}, 32'(a_if.tx_underrun), 32'd0);
  endtask

  initial begin
    int b0, d0, u0, r0;
    a_if.tx_start = 1'b0; a_if.data_len_ext = '0; a_if.din = '0; a_if.din_valid = 1'b0;
    b_if.tx_start = 1'b0; b_if.data_len_ext = '0; b_if.din = '0; b_if.din_valid = 1'b0;

    // Reset values
    #2;
    check_idle_a("rst");
    check("rst_b_busy", 32'(b_if.tx_busy), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // T1: len=2, data 3 then F, source always valid
    feed_a = '{4'h3, 4'hF};
    feed_en_a = 1'b1;
    push_frame(1'b0, 16'd2);
    push_sym(1'b0, 4'h3);
    push_sym(1'b0, 4'hF);
    b0 = busy_a; d0 = done_a; u0 = und_a;
    start(1'b0, 16'd2);
    wait_end(1'b0, "t1");
    check("t1_busy_cycles", 32'(busy_a - b0), 32'd224);
    check("t1_done_pulses", 32'(done_a - d0), 32'd1);
    check("t1_underruns", 32'(und_a - u0), 32'd0);
    check("t1_exp_left", 32'(exp_a.size()), 32'd0);
    check("t1_feed_left", 32'(feed_a.size()), 32'd0);
    check_idle_a("t1_after");

    // T2: CHIP_BITS=3, len=1, data 5
    feed_b = '{4'h5};
    feed_en_b = 1'b1;
    push_frame(1'b1, 16'd1);
    push_sym(1'b1, 4'h5);
    b0 = busy_b; d0 = done_b;
    start(1'b1, 16'd1);
    wait_end(1'b1, "t2");
    check("t2_busy_cycles", 32'(busy_b - b0), 32'd624);
    check("t2_done_pulses", 32'(done_b - d0), 32'd1);
    check("t2_exp_left", 32'(exp_b.size()), 32'd0);
    check("t2_dout_idle", 32'(b_if.dout), 32'd0);

    // T3: len=0, source offers data that must never be taken
    feed_a = '{4'h9};
    feed_en_a = 1'b1;
    push_frame(1'b0, 16'd0);
    b0 = busy_a; d0 = done_a; r0 = ready_a;
    start(1'b0, 16'd0);
    wait_end(1'b0, "t3");
    check("t3_busy_cycles", 32'(busy_a - b0), 32'd192);
    check("t3_done_pulses", 32'(done_a - d0), 32'd1);
    check("t3_ready_cycles", 32'(ready_a - r0), 32'd0);
    check("t3_feed_left", 32'(feed_a.size()), 32'd1);
    feed_a.delete();
    feed_en_a = 1'b0;
    tick();

    // T4: len=3 but only one symbol supplied -> underrun at second data boundary
    feed_a = '{4'h7};
    feed_en_a = 1'b1;
    push_frame(1'b0, 16'd3);
    push_sym(1'b0, 4'h7);
    b0 = busy_a; d0 = done_a; u0 = und_a;
    start(1'b0, 16'd3);
    wait_end(1'b0, "t4");
    check("t4_busy_cycles", 32'(busy_a - b0), 32'd208);
    check("t4_underruns", 32'(und_a - u0), 32'd1);
    check("t4_done_pulses", 32'(done_a - d0), 32'd0);
    check("t4_exp_left", 32'(exp_a.size()), 32'd0);
    check_idle_a("t4_after");
    feed_en_a = 1'b0;

    // T5: first valid arrives exactly on the edge ending the last header symbol (bypass)
    feed_a = '{4'hA};
    push_frame(1'b0, 16'd1);
    push_sym(1'b0, 4'hA);
    b0 = busy_a; d0 = done_a; u0 = und_a;
    start(1'b0, 16'd1);
    repeat (190) tick();
    feed_en_a = 1'b1;
    wait_end(1'b0, "t5");
    check("t5_busy_cycles", 32'(busy_a - b0), 32'd208);
    check("t5_underruns", 32'(und_a - u0), 32'd0);
    check("t5_done_pulses", 32'(done_a - d0), 32'd1);
    check("t5_exp_left", 32'(exp_a.size()), 32'd0);
    check("t5_feed_left", 32'(feed_a.size()), 32'd0);

    // T6: asynchronous reset mid-header, then a clean packet
    feed_a = '{4'h1, 4'h2};
    feed_en_a = 1'b1;
    push_frame(1'b0, 16'd2);
    start(1'b0, 16'd2);
    repeat (150) tick();
    check("t6_busy_before_rst", 32'(a_if.tx_busy), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check_idle_a("t6_rst");
    exp_a.delete();
    feed_a.delete();
    feed_en_a = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    feed_a = '{4'hC};
    feed_en_a = 1'b1;
    push_frame(1'b0, 16'd1);
    push_sym(1'b0, 4'hC);
    b0 = busy_a; d0 = done_a;
    start(1'b0, 16'd1);
    wait_end(1'b0, "t6");
    check("t6_busy_cycles", 32'(busy_a - b0), 32'd208);
    check("t6_done_pulses", 32'(done_a - d0), 32'd1);
    check("t6_exp_left", 32'(exp_a.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
